// File: rtl/strela_exec_ctrl.sv
// STRELA execution sequencer: config load, execution phase, loaded-config tracking, perf counters.
// Define STRELA_EXEC_TIMEOUT_EN to add the exec-phase watchdog (otherwise timeout_o is tied low).
module strela_exec_ctrl #(
  parameter int unsigned OUTPUT_NODES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  input  logic                          clr_conf_i,
  input  logic                          perf_ctr_en_i,
  input  logic                          perf_ctr_rst_i,
  input  logic [15:0]                   conf_size_i,
  input  logic [OUTPUT_NODES-1:0][15:0] omn_size_i,
  input  logic                          conf_fin_i,
  input  logic [OUTPUT_NODES-1:0]       omn_done_i,
  input  logic                          stall_i,
  output logic                          conf_start_o,
  output logic                          exec_start_o,
  output logic                          conf_done_o,
  output logic                          exec_done_o,
  output logic                          busy_o,
  output logic                          timeout_o,
  output logic [31:0]                   perf_ctr_total_cycles_o,
  output logic [31:0]                   perf_ctr_conf_cycles_o,
  output logic [31:0]                   perf_ctr_exec_cycles_o,
  output logic [31:0]                   perf_ctr_stall_cycles_o
);

  // state | meaning
  // IDLE  | waiting for start_i; clr_conf_i honoured here only
  // CONF  | config loader running, waiting for conf_fin_i
  // EXEC  | IMNs/OMNs running, waiting for every active OMN to report done
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONF = 2'd1,
    EXEC = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic                    conf_loaded_q, conf_loaded_d;
  logic                    loaded_eff;
  logic [OUTPUT_NODES-1:0] act_q, act_d, act_now;
  logic [OUTPUT_NODES-1:0] done_q, done_d;
  logic                    conf_start_d, exec_start_d, conf_done_d, exec_done_d, timeout_d;

`ifdef STRELA_EXEC_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Down-counter loaded in the EXEC entry cycle; terminal count lands exactly TIMEOUT_CYCLES in.
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES - 2);
  logic [WD_W-1:0] wd_q, wd_d;
`endif

  always_comb begin
    act_now = '0;
    for (int i = 0; i < OUTPUT_NODES; i++) begin
      act_now[i] = (omn_size_i[i] != 16'd0);
    end
  end

  always_comb begin
    state_d       = state_q;
    conf_loaded_d = conf_loaded_q;
    act_d         = act_q;
    done_d        = done_q;
    conf_start_d  = 1'b0;
    exec_start_d  = 1'b0;
    conf_done_d   = 1'b0;
    exec_done_d   = 1'b0;
    timeout_d     = 1'b0;
    loaded_eff    = conf_loaded_q & ~clr_conf_i;
`ifdef STRELA_EXEC_TIMEOUT_EN
    wd_d          = wd_q;
`endif
    case (state_q)
      IDLE: begin
        conf_loaded_d = loaded_eff;
        if (start_i) begin
          if (!loaded_eff && (conf_size_i != 16'd0)) begin
            state_d      = CONF;
            conf_start_d = 1'b1;
          end else begin
            state_d      = EXEC;
            exec_start_d = 1'b1;
            if (!loaded_eff) begin
              conf_loaded_d = 1'b1;
              conf_done_d   = 1'b1;
            end
          end
        end
      end
      CONF: begin
        if (conf_fin_i) begin
          state_d       = EXEC;
          conf_loaded_d = 1'b1;
          conf_done_d   = 1'b1;
          exec_start_d  = 1'b1;
        end
      end
      EXEC: begin
        // exec_start_o is high exactly in the first EXEC cycle: latch the active mask there.
        if (exec_start_o) begin
          act_d  = act_now;
          done_d = omn_done_i;
`ifdef STRELA_EXEC_TIMEOUT_EN
          wd_d   = WD_LOAD;
`endif
        end else begin
          done_d = done_q | omn_done_i;
          if (&(done_d | ~act_q)) begin
            state_d     = IDLE;
            exec_done_d = 1'b1;
          end
`ifdef STRELA_EXEC_TIMEOUT_EN
          else if (wd_q == '0) begin
            state_d     = IDLE;
            exec_done_d = 1'b1;
            timeout_d   = 1'b1;
          end else begin
            wd_d = wd_q - WD_W'(1);
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      conf_loaded_q <= 1'b0;
      act_q         <= '0;
      done_q        <= '0;
      conf_start_o  <= 1'b0;
      exec_start_o  <= 1'b0;
      conf_done_o   <= 1'b0;
      exec_done_o   <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      state_q       <= state_d;
      conf_loaded_q <= conf_loaded_d;
      act_q         <= act_d;
      done_q        <= done_d;
      conf_start_o  <= conf_start_d;
      exec_start_o  <= exec_start_d;
      conf_done_o   <= conf_done_d;
      exec_done_o   <= exec_done_d;
      busy_o        <= (state_d != IDLE);
    end
  end

`ifdef STRELA_EXEC_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_q      <= '0;
      timeout_o <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_o <= timeout_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = timeout_d | (TIMEOUT_CYCLES == 0);
  assign timeout_o      = 1'b0;
`endif

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Counters track the state held during the cycle; a clear pulse beats any increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_ctr_total_cycles_o <= '0;
      perf_ctr_conf_cycles_o  <= '0;
      perf_ctr_exec_cycles_o  <= '0;
      perf_ctr_stall_cycles_o <= '0;
    end else if (perf_ctr_rst_i) begin
      perf_ctr_total_cycles_o <= '0;
      perf_ctr_conf_cycles_o  <= '0;
      perf_ctr_exec_cycles_o  <= '0;
      perf_ctr_stall_cycles_o <= '0;
    end else if (perf_ctr_en_i) begin
      if (state_q != IDLE) perf_ctr_total_cycles_o <= sat_inc(perf_ctr_total_cycles_o);
      if (state_q == CONF) perf_ctr_conf_cycles_o <= sat_inc(perf_ctr_conf_cycles_o);
      if (state_q == EXEC) begin
        perf_ctr_exec_cycles_o <= sat_inc(perf_ctr_exec_cycles_o);
        if (stall_i) perf_ctr_stall_cycles_o <= sat_inc(perf_ctr_stall_cycles_o);
      end
    end
  end

endmodule

// File: tb/tb_strela_exec_ctrl.sv
// Bench for strela_exec_ctrl: directed scenarios plus randomized runs checked against an
// event-time model (entry cycle, completion cycle, per-cycle counter accrual).
module tb_strela_exec_ctrl;
  localparam int N  = 4;
  localparam int TO = 16;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              start_i, clr_conf_i, perf_ctr_en_i, perf_ctr_rst_i;
  logic [15:0]       conf_size_i;
  logic [N-1:0][15:0] omn_size_i;
  logic              conf_fin_i;
  logic [N-1:0]      omn_done_i;
  logic              stall_i;
  logic              conf_start_o, exec_start_o, conf_done_o, exec_done_o, busy_o, timeout_o;
  logic [31:0]       ctr_total, ctr_conf, ctr_exec, ctr_stall;

  strela_exec_ctrl #(.OUTPUT_NODES(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .clr_conf_i(clr_conf_i),
    .perf_ctr_en_i(perf_ctr_en_i), .perf_ctr_rst_i(perf_ctr_rst_i),
    .conf_size_i(conf_size_i), .omn_size_i(omn_size_i), .conf_fin_i(conf_fin_i),
    .omn_done_i(omn_done_i), .stall_i(stall_i),
    .conf_start_o(conf_start_o), .exec_start_o(exec_start_o), .conf_done_o(conf_done_o),
    .exec_done_o(exec_done_o), .busy_o(busy_o), .timeout_o(timeout_o),
    .perf_ctr_total_cycles_o(ctr_total), .perf_ctr_conf_cycles_o(ctr_conf),
    .perf_ctr_exec_cycles_o(ctr_exec), .perf_ctr_stall_cycles_o(ctr_stall)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;

  // reference model state
  bit          m_loaded;
  logic [31:0] m_tot, m_conf, m_exec, m_stall;

  // per-run stimulus description
  bit                 r_clr, r_noise;
  logic [15:0]        r_csz;
  int                 r_fin, r_rst_cyc;
  logic [N-1:0][15:0] r_osz;
  int                 r_done [N];
  bit                 en_at [256];
  bit                 stall_at [256];

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic model_zero();
    m_tot = '0; m_conf = '0; m_exec = '0; m_stall = '0;
  endtask

  task automatic check_ctrs(input string tag);
    check({tag, ".total"}, ctr_total, m_tot);
    check({tag, ".conf"},  ctr_conf,  m_conf);
    check({tag, ".exec"},  ctr_exec,  m_exec);
    check({tag, ".stall"}, ctr_stall, m_stall);
  endtask

  task automatic prep(input bit clr, input logic [15:0] csz, input int fin);
    r_clr = clr; r_csz = csz; r_fin = fin; r_noise = 0; r_rst_cyc = -1; r_osz = '0;
    for (int i = 0; i < N; i++) r_done[i] = -1;
    for (int c = 0; c < 256; c++) begin en_at[c] = 1; stall_at[c] = 0; end
  endtask

  task automatic idle_inputs();
    start_i = 0; clr_conf_i = 0; conf_fin_i = 0; omn_done_i = '0; stall_i = 0;
    perf_ctr_rst_i = 0; perf_ctr_en_i = 1;
  endtask

  task automatic perf_clear();
    perf_ctr_rst_i = 1; step(); perf_ctr_rst_i = 0;
    model_zero();
  endtask

  task automatic clr_idle();
    clr_conf_i = 1; step(); clr_conf_i = 0;
    m_loaded = 0;
  endtask

  // Start is sampled at edge 0; cycle c is the interval after edge c.
  task automatic run(input string tag);
    bit leff, need, to_exp;
    int e, m, ns, nc;
    int c_cs, c_es, c_cd, c_ed, c_to, c_idle;
    int n_cs, n_es, n_cd, n_ed, n_to;
    logic [31:0] x_tot, x_conf, x_exec, x_stall;
    leff = m_loaded && !r_clr;
    need = !leff && (r_csz != 16'd0);
    e = need ? r_fin : 0;
    m = e + 2;
    for (int i = 0; i < N; i++) begin
      if (r_osz[i] != 16'd0) begin
        if (r_done[i] < 0) m = 1 << 20;
        else if (r_done[i] > m) m = r_done[i];
      end
    end
    to_exp = 0;
`ifdef STRELA_EXEC_TIMEOUT_EN
    if (m > e + TO) begin m = e + TO; to_exp = 1; end
`endif
    for (int c = 0; c < m; c++) begin
      if (c == r_rst_cyc) begin
        model_zero();
      end else if (en_at[c]) begin
        m_tot = inc(m_tot);
        if (need && c < e) m_conf = inc(m_conf);
        if (c >= e) begin
          m_exec = inc(m_exec);
          if (stall_at[c]) m_stall = inc(m_stall);
        end
      end
    end
    ns = $urandom_range(m - 1, 0);
    nc = $urandom_range(m - 1, 0);
    c_cs = -1; c_es = -1; c_cd = -1; c_ed = -1; c_to = -1; c_idle = -1;
    n_cs = 0; n_es = 0; n_cd = 0; n_ed = 0; n_to = 0;
    x_tot = '0; x_conf = '0; x_exec = '0; x_stall = '0;

    start_i = 1; clr_conf_i = r_clr; conf_size_i = r_csz; omn_size_i = r_osz;
    omn_done_i = (r_noise && e == 0) ? '1 : '0;
    conf_fin_i = r_noise; stall_i = 0; perf_ctr_rst_i = 0; perf_ctr_en_i = 1;
    step();
    for (int c = 0; c <= m + 2; c++) begin
      if (conf_start_o) begin if (c_cs < 0) c_cs = c; n_cs++; end
      if (exec_start_o) begin if (c_es < 0) c_es = c; n_es++; end
      if (conf_done_o)  begin if (c_cd < 0) c_cd = c; n_cd++; end
      if (exec_done_o)  begin if (c_ed < 0) c_ed = c; n_ed++; end
      if (timeout_o)    begin if (c_to < 0) c_to = c; n_to++; end
      if (!busy_o && c_idle < 0) c_idle = c;
      if (c == m) begin x_tot = ctr_total; x_conf = ctr_conf; x_exec = ctr_exec; x_stall = ctr_stall; end
      start_i    = r_noise && (c == ns);
      clr_conf_i = r_noise && (c == nc);
      conf_fin_i = (need && c == e - 1) || (r_noise && c == e);
      for (int i = 0; i < N; i++) begin
        omn_done_i[i] = (c == r_done[i] - 1) ||
          (r_noise && (c == e - 1 || (r_osz[i] == 16'd0 && $urandom_range(2, 0) == 0) ||
                       (r_done[i] > 0 && c == r_done[i])));
        omn_size_i[i] = (r_noise && c > e) ? 16'($urandom) : r_osz[i];
      end
      stall_i        = stall_at[c];
      perf_ctr_en_i  = en_at[c];
      perf_ctr_rst_i = (c == r_rst_cyc);
      step();
    end
    idle_inputs();

    check({tag, ".conf_start_cyc"}, c_cs, need ? 0 : -1);
    check({tag, ".conf_start_n"},   n_cs, need ? 1 : 0);
    check({tag, ".exec_start_cyc"}, c_es, e);
    check({tag, ".exec_start_n"},   n_es, 1);
    check({tag, ".conf_done_cyc"},  c_cd, leff ? -1 : e);
    check({tag, ".conf_done_n"},    n_cd, leff ? 0 : 1);
    check({tag, ".exec_done_cyc"},  c_ed, m);
    check({tag, ".exec_done_n"},    n_ed, 1);
    check({tag, ".timeout_cyc"},    c_to, to_exp ? m : -1);
    check({tag, ".timeout_n"},      n_to, to_exp ? 1 : 0);
    check({tag, ".idle_cyc"},       c_idle, m);
    check({tag, ".ctr_total"},      x_tot,   m_tot);
    check({tag, ".ctr_conf"},       x_conf,  m_conf);
    check({tag, ".ctr_exec"},       x_exec,  m_exec);
    check({tag, ".ctr_stall"},      x_stall, m_stall);
    m_loaded = 1;
  endtask

  initial begin
    bit need;
    int e, n_cd, n_ed, n_busy;
    idle_inputs();
    conf_size_i = '0; omn_size_i = '0;
    rst_ni = 0;
    m_loaded = 0; model_zero();
    repeat (3) @(posedge clk_i);
    #1;
    check("rst.busy", busy_o, 0);
    check("rst.conf_start", conf_start_o, 0);
    check("rst.exec_start", exec_start_o, 0);
    check("rst.conf_done", conf_done_o, 0);
    check("rst.exec_done", exec_done_o, 0);
    check("rst.timeout", timeout_o, 0);
    check_ctrs("rst");
    rst_ni = 1;
    step();

    // nominal: conf_fin at +10, OMN2/OMN3 done at +20/+25
    prep(0, 16'd8, 10);
    r_osz[2] = 16'd4; r_osz[3] = 16'd4; r_done[2] = 20; r_done[3] = 25;
    run("t1");
    check("t1.conf10", ctr_conf, 10);

    // loaded config is reused; explicit clear forces a reload
    prep(0, 16'd8, 5); r_osz[0] = 16'd7; r_done[0] = 6;
    run("t2_skip");
    prep(1, 16'd8, 4); r_osz[1] = 16'd3; r_done[1] = 7;
    run("t2_reload");

    // start/clear/conf_fin/done noise while busy
    prep(0, 16'd8, 3); r_noise = 1;
    r_osz[0] = 16'd2; r_osz[3] = 16'd9; r_done[0] = 10; r_done[3] = 14;
    run("t3_noise");
    prep(0, 16'd8, 3); r_osz[2] = 16'd1; r_done[2] = 5;
    run("t3_after");

    // stall accounting, disabled counting, clear racing an increment
    perf_clear();
    prep(1, 16'd3, 5); r_osz[0] = 16'd4; r_done[0] = 18;
    for (int c = 1; c <= 3; c++) stall_at[c] = 1;
    for (int c = 6; c <= 12; c++) stall_at[c] = 1;
    run("t4_stall");
    check("t4.stall7", ctr_stall, 7);
    prep(0, 16'd3, 5); r_osz[1] = 16'd5; r_done[1] = 8;
    for (int c = 0; c < 256; c++) begin en_at[c] = 0; stall_at[c] = 1; end
    run("t4_en0");
    prep(0, 16'd3, 5); r_osz[0] = 16'd1; r_done[0] = 9; r_rst_cyc = 8;
    run("t4_rst");
    check("t4.rst_total0", ctr_total, 0);

    // no active OMNs; zero-size config with nothing loaded
    prep(0, 16'd0, 1);
    run("t5_none_loaded");
    prep(1, 16'd4, 3);
    run("t5_none_conf");
    clr_idle();
    prep(0, 16'd0, 1); r_osz[3] = 16'd2; r_done[3] = 4;
    run("t5_csz0");

    // reset in the middle of CONF
    start_i = 1; clr_conf_i = 1; conf_size_i = 16'd5;
    step();
    start_i = 0; clr_conf_i = 0;
    step(); step();
    check("rstmid.busy_before", busy_o, 1);
    rst_ni = 0;
    #1;
    check("rstmid.busy", busy_o, 0);
    check("rstmid.conf_start", conf_start_o, 0);
    check("rstmid.ctr_total", ctr_total, 0);
    m_loaded = 0; model_zero();
    @(posedge clk_i); #1;
    rst_ni = 1;
    n_cd = 0; n_ed = 0; n_busy = 0;
    conf_fin_i = 1; omn_done_i = '1;
    for (int c = 0; c < 6; c++) begin
      step();
      conf_fin_i = 0; omn_done_i = '0;
      if (conf_done_o) n_cd++;
      if (exec_done_o) n_ed++;
      if (busy_o) n_busy++;
    end
    check("rstmid.conf_done_n", n_cd, 0);
    check("rstmid.exec_done_n", n_ed, 0);
    check("rstmid.busy_n", n_busy, 0);

    // OMNs that never finish
`ifdef STRELA_EXEC_TIMEOUT_EN
    prep(0, 16'd0, 1);
    for (int i = 0; i < N; i++) r_osz[i] = 16'd4;
    run("t6_timeout");
`else
    conf_size_i = '0; omn_size_i = {N{16'd4}};
    start_i = 1; step(); start_i = 0;
    n_ed = 0;
    for (int c = 0; c < 1000; c++) begin
      if (exec_done_o) n_ed++;
      step();
    end
    check("t6.busy_1000", busy_o, 1);
    check("t6.exec_done_n", n_ed, 0);
    rst_ni = 0; @(posedge clk_i); #1; rst_ni = 1; step();
    m_loaded = 0; model_zero();
`endif
    // done pulse in the EXEC entry cycle
    prep(0, 16'd8, 2); r_osz[0] = 16'd1; r_done[0] = 3;
    run("t6_after");

    for (int k = 0; k < 25; k++) begin
      prep($urandom_range(3, 0) == 0, ($urandom_range(2, 0) == 0) ? 16'd0 : 16'($urandom_range(100, 1)),
           $urandom_range(12, 1));
      need = !(m_loaded && !r_clr) && (r_csz != 16'd0);
      e = need ? r_fin : 0;
      for (int i = 0; i < N; i++) begin
        r_osz[i] = ($urandom_range(2, 0) == 0) ? 16'd0 : 16'($urandom_range(50, 1));
        if (r_osz[i] != 16'd0) r_done[i] = e + $urandom_range(22, 1);
      end
      for (int c = 0; c < 256; c++) begin
        en_at[c] = ($urandom_range(4, 0) != 0);
        stall_at[c] = $urandom_range(1, 0) == 1;
      end
      if ($urandom_range(4, 0) == 0) r_rst_cyc = $urandom_range(e + 1, 0);
      r_noise = $urandom_range(1, 0) == 1;
      run($sformatf("rnd%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
